// File: rtl/dpe_ingress_arb.sv
// dpe_ingress_arb: packet-level round-robin arbiter sharing the DPE ingress among NUM_SRC streams.
// Optional build macro DPE_ARB_PKT_CNT_EN adds per-source packet counters (pkt_cnt, pkt_cnt_clr).

module dpe_arb_lane #(
  parameter int DATA_W = 8
) (
  input  logic                  sel,
  input  logic [DATA_W-1:0]     tdata,
  input  logic [DATA_W/8-1:0]   tkeep,
  input  logic                  tlast,
  input  logic                  tvalid,
  input  logic                  out_tready,
  output logic [DATA_W-1:0]     m_tdata,
  output logic [DATA_W/8-1:0]   m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  output logic                  tready
);
  // Unselected lanes contribute zero so the top can OR-reduce.
  assign m_tdata  = sel ? tdata : '0;
  assign m_tkeep  = sel ? tkeep : '0;
  assign m_tlast  = sel & tlast;
  assign m_tvalid = sel & tvalid;
  assign tready   = sel & out_tready;
endmodule

`ifdef DPE_ARB_PKT_CNT_EN
module dpe_arb_pkt_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] cnt
);
  // Clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= cnt + 32'd1;
  end
endmodule
`endif

module dpe_ingress_arb #(
  parameter int NUM_SRC = 5,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_W-1:0]     in_tdata,
  input  logic [NUM_SRC*(DATA_W/8)-1:0] in_tkeep,
  input  logic [NUM_SRC-1:0]            in_tlast,
  input  logic [NUM_SRC-1:0]            in_tvalid,
  output logic [NUM_SRC-1:0]            in_tready,
  output logic [DATA_W-1:0]             out_tdata,
  output logic [DATA_W/8-1:0]           out_tkeep,
  output logic                          out_tlast,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic [ID_W-1:0]               out_tid,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy
`ifdef DPE_ARB_PKT_CNT_EN
  ,
  input  logic                          pkt_cnt_clr,
  output logic [NUM_SRC*32-1:0]         pkt_cnt
`endif
);
  localparam int KEEP_W = DATA_W/8;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                           state_q, state_d;
  logic [NUM_SRC-1:0]               grant_q, pick_oh;
  logic [ID_W-1:0]                  tid_q, last_q, pick_id;
  logic                             pick_vld, release_w;
  logic [NUM_SRC-1:0][DATA_W-1:0]   lane_data;
  logic [NUM_SRC-1:0][KEEP_W-1:0]   lane_keep;
  logic [NUM_SRC-1:0]               lane_last, lane_vld;

  // Round-robin: first pass covers indices above last-served, second pass wraps to 0..last.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    pick_oh  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!pick_vld && in_tvalid[i] && (ID_W'(i) > last_q)) begin
        pick_vld   = 1'b1;
        pick_id    = ID_W'(i);
        pick_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!pick_vld && in_tvalid[i] && (ID_W'(i) <= last_q)) begin
        pick_vld   = 1'b1;
        pick_id    = ID_W'(i);
        pick_oh[i] = 1'b1;
      end
    end
  end

  assign release_w = (state_q == LOCK) & out_tvalid & out_tready & out_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      tid_q   <= '0;
      last_q  <= ID_W'(NUM_SRC-1);
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_vld) begin
        grant_q <= pick_oh;
        tid_q   <= pick_id;
      end else if (release_w) begin
        grant_q <= '0;
        last_q  <= tid_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld)  state_d = LOCK;
      LOCK:    if (release_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // grant_q is only non-zero in LOCK, so the lanes gate the datapath for both states.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    dpe_arb_lane #(.DATA_W(DATA_W)) u_lane (
      .sel        (grant_q[g]),
      .tdata      (in_tdata[g*DATA_W +: DATA_W]),
      .tkeep      (in_tkeep[g*KEEP_W +: KEEP_W]),
      .tlast      (in_tlast[g]),
      .tvalid     (in_tvalid[g]),
      .out_tready (out_tready),
      .m_tdata    (lane_data[g]),
      .m_tkeep    (lane_keep[g]),
      .m_tlast    (lane_last[g]),
      .m_tvalid   (lane_vld[g]),
      .tready     (in_tready[g])
    );
  end

  always_comb begin
    out_tdata  = '0;
    out_tkeep  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      out_tdata = out_tdata | lane_data[i];
      out_tkeep = out_tkeep | lane_keep[i];
    end
    out_tlast  = |lane_last;
    out_tvalid = |lane_vld;
    out_tid    = tid_q;
    grant      = grant_q;
    busy       = (state_q == LOCK);
  end

`ifdef DPE_ARB_PKT_CNT_EN
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
    dpe_arb_pkt_ctr u_ctr (
      .clk (clk),
      .rst (rst),
      .clr (pkt_cnt_clr),
      .inc (release_w & grant_q[g]),
      .cnt (pkt_cnt[g*32 +: 32])
    );
  end
`endif

endmodule
